// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: op codes, default latencies and FSM state codes.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MdNone  = 3'd0,
    MdMult  = 3'd1,
    MdMultu = 3'd2,
    MdDiv   = 3'd3,
    MdDivu  = 3'd4,
    MdMthi  = 3'd5,
    MdMtlo  = 3'd6,
    MdRsvd  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  function automatic logic md_is_arith(md_op_e op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic md_is_mult(md_op_e op);
    return (op == MdMult) || (op == MdMultu);
  endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational multiply/divide datapath producing the full HI/LO result for one operation.
module md_unit_calc
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] pending_hi,
  output logic [31:0] pending_lo,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] rs_s;
  logic signed [31:0] rt_s;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               rt_zero;
  logic               div_ovf;

  assign rs_s    = $signed(rs);
  assign rt_s    = $signed(rt);
  assign rt_zero = (rt == 32'd0);
  // Most negative value divided by -1 overflows; the architectural answer wraps.
  assign div_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  always_comb begin
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (!rt_zero) begin
      if (div_ovf) begin
        quot_s = 32'sh8000_0000;
        rem_s  = '0;
      end else begin
        quot_s = rs_s / rt_s;
        rem_s  = rs_s % rt_s;
      end
      quot_u = rs / rt;
      rem_u  = rs % rt;
    end
  end

  always_comb begin
    pending_hi = '0;
    pending_lo = '0;
    div_zero   = 1'b0;
    case (op)
      MdMult: begin
        pending_hi = prod_s[63:32];
        pending_lo = prod_s[31:0];
      end
      MdMultu: begin
        pending_hi = prod_u[63:32];
        pending_lo = prod_u[31:0];
      end
      MdDiv: begin
        pending_hi = rem_s;
        pending_lo = quot_s;
        div_zero   = rt_zero;
      end
      MdDivu: begin
        pending_hi = rem_u;
        pending_lo = quot_u;
        div_zero   = rt_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO and models multi-cycle latency with a busy counter.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_op_e          op;
  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic [31:0]     pend_hi_q;
  logic [31:0]     pend_lo_q;
  logic            pend_zero_q;
  logic [31:0]     calc_hi;
  logic [31:0]     calc_lo;
  logic            calc_zero;

  assign op = md_op_e'(md_op);

  md_unit_calc u_calc (
    .op         (op),
    .rs         (rs_val),
    .rt         (rt_val),
    .pending_hi (calc_hi),
    .pending_lo (calc_lo),
    .div_zero   (calc_zero)
  );

  assign start = md_is_arith(op) && (state_q == StIdle);
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_is_arith(op)) begin
            pend_hi_q   <= calc_hi;
            pend_lo_q   <= calc_lo;
            pend_zero_q <= calc_zero;
            cnt_q       <= md_is_mult(op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            busy_q      <= 1'b1;
            state_q     <= StRun;
          end else if (op == MdMthi) begin
            hi_q <= rs_val;
          end else if (op == MdMtlo) begin
            lo_q <= rs_val;
          end
        end
        StRun: begin
          // Ops arriving while running are dropped; the hazard unit should never send them.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            if (!pend_zero_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit of the P5 pipeline.
- Directly downstream of the decoder: consumes the mult/multu/div/divu/mthi/mtlo class the decoder identifies, carried to E as md_op with forwarded rs/rt values.
- Owns the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter; the hazard unit stalls md-class instructions in D while start or busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  in  32  forwarded rt operand (divisor / multiplier)
- start  out  1  combinational: md_op in 1..4 and state IDLE (hazard unit uses start|busy)
- busy  out  1  registered; high while an operation is in flight
- hi  out  32  architectural HI (mfhi source)
- lo  out  32  architectural LO (mflo source)

Behaviour:
Reset and interface:
- Reset: hi=0, lo=0, busy=0, counter=0, state IDLE, pending results cleared.
- All state updates on the rising clk edge.
- Reset dominates every other input in the same cycle.
- Reset mid-operation aborts: pending results discarded, hi/lo cleared.

States:
- IDLE
  - md_op 1..4 sampled at edge T0: compute full result into pending_hi/pending_lo; load counter with MULT_CYCLES or DIV_CYCLES; busy<=1; go to RUN.
  - md_op 5: hi<=rs_val at that edge.
  - md_op 6: lo<=rs_val at that edge.
  - Both move-to ops leave busy at 0.
- RUN
  - Counter decrements each edge.
  - busy is high for exactly N cycles, T0+1..T0+N.
  - At the edge ending cycle T0+N: hi<=pending_hi, lo<=pending_lo, busy<=0, go to IDLE.
  - New values and busy=0 are visible together in cycle T0+N+1.
  - Any md_op in RUN, including mthi/mtlo, is ignored. The hazard unit guarantees none arrive; the bench checks that they are ignored anyway.
  - hi/lo outputs keep their old values throughout RUN.
  - An op issued in the cycle busy falls is accepted normally: back-to-back ops are allowed.

Arithmetic:
- mult: signed 32x32, 64-bit product; hi=[63:32], lo=[31:0].
- multu: unsigned 32x32, same split.
- div (signed): lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- div special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (rt_val=0): the operation still occupies DIV_CYCLES; hi/lo are left unchanged at completion.

Decomposition:
- Shared const.v gets:
  - MD_none..MD_mtlo op codes
  - MD_MULT_CYCLES / MD_DIV_CYCLES defaults
  - MD_IDLE / MD_RUN state codes
- Decoder and E-stage pipeline register use the same MD_* codes.
- One sub-module is natural: md_calc, combinational, taking op/rs/rt and returning pending_hi, pending_lo, div_zero. It isolates the signed/unsigned and divide-edge-case arithmetic.
- md_unit keeps the FSM, counter and HI/LO registers.

Test Plan:
1. mult rs=0xFFFFFFFE (-2), rt=3:
   - start=1 in T0; busy=1 for exactly 5 cycles.
   - Cycle T0+6: busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
3. div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. Divide edge cases:
   - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
   - divu 7/0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
5. Move-to ops and ignore-while-busy:
   - mthi 0xAAAA5555 then mtlo 0x1234 on consecutive cycles -> hi/lo update next edge, busy stays 0.
   - mtlo 0xDEAD issued during a mult's RUN -> ignored; lo ends as the mult result.
6. Reset and back-to-back:
   - Reset asserted at busy cycle 3 of a div -> next cycle busy=0, hi=lo=0, no late write-back.
   - multu issued in the cycle busy falls -> accepted; busy goes high again next cycle.
